// File: rtl/regfile_param_nrd.sv
// rtl/regfile_param_nrd.sv - register file, one write port, N_RD registered read ports, clear sequencer
// Optional same-cycle write-to-read forwarding: define REGFILE_WR_BYPASS_EN.
module regfile_param_nrd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  output logic                     o_busy,
  input  logic                     i_wrEn,
  input  logic [ADDR_W-1:0]        i_wrAdd,
  input  logic [DATA_W-1:0]        i_wrData,
  input  logic [N_RD-1:0]          i_rdEn,
  input  logic [N_RD*ADDR_W-1:0]   i_rdAdd,
  output logic [N_RD*DATA_W-1:0]   o_rdData,
  output logic [N_RD-1:0]          o_rdValid
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clrPtr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wrZero;
  logic                wrHit;
  logic [ADDR_W-1:0]   rdAddr [N_RD];
  logic [DATA_W-1:0]   rdWord [N_RD];

  // A write only lands in READY, when no clear is starting and it does not target a hardwired zero.
  always_comb begin
    wrZero = (ZERO_REG != 0) && (i_wrAdd == '0);
    wrHit  = (state == READY) && i_wrEn && !i_clear && !wrZero;
  end

  always_comb begin
    for (int k = 0; k < N_RD; k++) begin
      rdAddr[k] = i_rdAdd[k*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (rdAddr[k] == '0)) begin
        rdWord[k] = '0;
`ifdef REGFILE_WR_BYPASS_EN
      end else if (wrHit && (rdAddr[k] == i_wrAdd)) begin
        rdWord[k] = i_wrData;
`endif
      end else begin
        rdWord[k] = mem[rdAddr[k]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= CLEAR;
      clrPtr <= '0;
      o_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clrPtr == ADDR_W'(DEPTH - 1)) begin
            state  <= READY;
            clrPtr <= '0;
            o_busy <= 1'b0;
          end else begin
            clrPtr <= clrPtr + ADDR_W'(1);
          end
        end
        READY: begin
          if (i_clear) begin
            state  <= CLEAR;
            clrPtr <= '0;
            o_busy <= 1'b1;
          end
        end
        default: begin
          state  <= CLEAR;
          clrPtr <= '0;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the sweep that follows every reset zeroes it.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state == CLEAR) begin
        mem[clrPtr] <= '0;
      end else if (wrHit) begin
        mem[i_wrAdd] <= i_wrData;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rdData  <= '0;
      o_rdValid <= '0;
    end else begin
      for (int k = 0; k < N_RD; k++) begin
        if (!i_rdEn[k]) begin
          o_rdValid[k] <= 1'b0;
        end else if (state == CLEAR) begin
          o_rdValid[k]                 <= 1'b0;
          o_rdData[k*DATA_W +: DATA_W] <= '0;
        end else begin
          o_rdValid[k]                 <= 1'b1;
          o_rdData[k*DATA_W +: DATA_W] <= rdWord[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_param_nrd.sv
// tb/tb_regfile_param_nrd.sv - randomized self-checking bench for regfile_param_nrd
// Reference model: plain array of register contents plus per-port last-returned data.
module tb_regfile_param_nrd;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_clear;
  logic        o_busy;
  logic        i_wrEn;
  logic [4:0]  i_wrAdd;
  logic [31:0] i_wrData;
  logic [1:0]  i_rdEn;
  logic [9:0]  i_rdAdd;
  logic [63:0] o_rdData;
  logic [1:0]  o_rdValid;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [31:0] lastData [2];

  regfile_param_nrd dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_clear),
    .o_busy    (o_busy),
    .i_wrEn    (i_wrEn),
    .i_wrAdd   (i_wrAdd),
    .i_wrData  (i_wrData),
    .i_rdEn    (i_rdEn),
    .i_rdAdd   (i_rdAdd),
    .o_rdData  (o_rdData),
    .o_rdValid (o_rdValid)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic zeroModel();
    for (int a = 0; a < 32; a++) model[a] = '0;
    lastData[0] = '0;
    lastData[1] = '0;
  endtask

  // One READY-state cycle: drive, predict from the model, clock, compare, update the model.
  task automatic doCycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
    logic [31:0] exp [2];
    logic [4:0]  ra [2];
    ra[0] = a0;
    ra[1] = a1;
    i_wrEn   = we;
    i_wrAdd  = wa;
    i_wrData = wd;
    i_rdEn   = re;
    i_rdAdd  = {a1, a0};
    for (int k = 0; k < 2; k++) begin
      if (!re[k]) exp[k] = lastData[k];
      else if (ra[k] == 5'd0) exp[k] = '0;
`ifdef REGFILE_WR_BYPASS_EN
      else if (we && ra[k] == wa) exp[k] = wd;
`endif
      else exp[k] = model[ra[k]];
    end
    tick();
    checkVal("rdValid0", 64'(o_rdValid[0]), 64'(re[0]));
    checkVal("rdValid1", 64'(o_rdValid[1]), 64'(re[1]));
    checkVal("rdData0", 64'(o_rdData[31:0]), 64'(exp[0]));
    checkVal("rdData1", 64'(o_rdData[63:32]), 64'(exp[1]));
    lastData[0] = exp[0];
    lastData[1] = exp[1];
    if (we && wa != 5'd0) model[wa] = wd;
    i_wrEn = 1'b0;
    i_rdEn = 2'b00;
  endtask

  task automatic readAll();
    for (int a = 0; a < 32; a++) doCycle(1'b0, 5'd0, 32'd0, 2'b11, 5'(a), 5'(31 - a));
  endtask

  task automatic randomPhase(input int n);
    for (int i = 0; i < n; i++)
      doCycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  task automatic countBusy(input string tag, input logic rdDuring);
    int n;
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      i_rdEn  = rdDuring ? 2'b11 : 2'b00;
      i_rdAdd = 10'($urandom);
      tick();
      if (rdDuring) begin
        checkVal({tag, "_validDuringClear"}, 64'(o_rdValid), 64'd0);
        checkVal({tag, "_dataDuringClear"}, o_rdData, 64'd0);
      end
    end
    i_rdEn = 2'b00;
    checkVal({tag, "_busyLen"}, 64'(n), 64'd32);
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_clear  = 1'b0;
    i_wrEn   = 1'b0;
    i_wrAdd  = '0;
    i_wrData = '0;
    i_rdEn   = 2'b11;
    i_rdAdd  = '0;
    zeroModel();

    // 1: reset, sweep length, all zero
    repeat (3) tick();
    checkVal("rstBusy", 64'(o_busy), 64'd1);
    checkVal("rstValid", 64'(o_rdValid), 64'd0);
    checkVal("rstData", o_rdData, 64'd0);
    i_rst_n = 1'b1;
    i_rdEn  = 2'b00;
    countBusy("init", 1'b0);
    readAll();

    // 2: write then read both ports
    doCycle(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
    doCycle(1'b0, 5'd0, 32'd0, 2'b11, 5'd5, 5'd5);
    checkVal("dualRead", o_rdData, 64'hDEADBEEF_DEADBEEF);
    checkVal("dualValid", 64'(o_rdValid), 64'd3);

    // 3: zero register
    doCycle(1'b1, 5'd0, 32'h12345678, 2'b00, 5'd0, 5'd0);
    doCycle(1'b0, 5'd0, 32'd0, 2'b01, 5'd0, 5'd0);
    checkVal("zeroReg", 64'(o_rdData[31:0]), 64'd0);

    // 4: read during write
    doCycle(1'b1, 5'd7, 32'hA, 2'b00, 5'd0, 5'd0);
    doCycle(1'b1, 5'd7, 32'hB, 2'b01, 5'd7, 5'd0);
`ifdef REGFILE_WR_BYPASS_EN
    checkVal("rdwSame", 64'(o_rdData[31:0]), 64'hB);
`else
    checkVal("rdwSame", 64'(o_rdData[31:0]), 64'hA);
`endif
    doCycle(1'b0, 5'd0, 32'd0, 2'b01, 5'd7, 5'd0);
    checkVal("rdwNext", 64'(o_rdData[31:0]), 64'hB);

    randomPhase(400);

    // 5: fill, then clear together with a write that must be lost
    for (int a = 1; a < 32; a++) doCycle(1'b1, 5'(a), 32'(a), 2'b00, 5'd0, 5'd0);
    i_clear  = 1'b1;
    i_wrEn   = 1'b1;
    i_wrAdd  = 5'd3;
    i_wrData = 32'hFF;
    tick();
    i_clear = 1'b0;
    i_wrEn  = 1'b0;
    countBusy("clear", 1'b1);
    zeroModel();
    readAll();

    // 6: reset in the middle of a sweep restarts it
    randomPhase(100);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    repeat (10) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    countBusy("midRst", 1'b0);
    zeroModel();
    readAll();
    randomPhase(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
